// File: rtl/timer_core.sv
// Machine-timer function block: 64-bit mtime with prescaler, two-stage
// unsigned compare against mtimecmp for the timer interrupt, and a registered
// copy of msip bit 0 for the software interrupt. Every output is a flop.
module timer_core #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic             mtime_we_lo,
    input  logic             mtime_we_hi,
    input  logic [31:0]      mtime_wdata,
    input  logic [63:0]      mtimecmp,
    input  logic [31:0]      msip_in,
    output logic [63:0]      mtime,
    output logic             tick,
    output logic             mtip,
    output logic             msip_irq
);

    logic [DIV_W-1:0] pre_cnt;
    logic             hi_gt;
    logic             hi_eq;
    logic             lo_ge;
    logic             load;

    assign load = mtime_we_lo | mtime_we_hi;

    // Prescaler and mtime: a software load beats the increment and restarts the prescaler.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime   <= 64'd0;
            pre_cnt <= '0;
            tick    <= 1'b0;
        end else if (load) begin
            if (mtime_we_lo) mtime[31:0]  <= mtime_wdata;
            if (mtime_we_hi) mtime[63:32] <= mtime_wdata;
            pre_cnt <= '0;
            tick    <= 1'b0;
        end else if (en) begin
            // >= so that lowering div below the running count ticks immediately.
            if (pre_cnt >= div) begin
                pre_cnt <= '0;
                mtime   <= mtime + 64'd1;
                tick    <= 1'b1;
            end else begin
                pre_cnt <= pre_cnt + DIV_W'(1);
                tick    <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

    // Compare stage 1: split the 64-bit compare into registered half results.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_gt <= 1'b0;
            hi_eq <= 1'b0;
            lo_ge <= 1'b0;
        end else begin
            hi_gt <= (mtime[63:32] >  mtimecmp[63:32]);
            hi_eq <= (mtime[63:32] == mtimecmp[63:32]);
            lo_ge <= (mtime[31:0]  >= mtimecmp[31:0]);
        end
    end

    // Compare stage 2: combine halves into the timer interrupt level.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtip <= 1'b0;
        end else begin
            mtip <= hi_gt | (hi_eq & lo_ge);
        end
    end

    // Software interrupt follows msip bit 0 one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            msip_irq <= 1'b0;
        end else begin
            msip_irq <= msip_in[0];
        end
    end

endmodule

// File: tb/tb_timer_core.sv
// Bench for timer_core: directed scenarios followed by randomized traffic.
// A reference model predicts each cycle's outputs into a queue; a monitor
// pops and compares after every rising edge.
module tb_timer_core;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] div;
    logic        mtime_we_lo;
    logic        mtime_we_hi;
    logic [31:0] mtime_wdata;
    logic [63:0] mtimecmp;
    logic [31:0] msip_in;
    logic [63:0] mtime;
    logic        tick;
    logic        mtip;
    logic        msip_irq;

    timer_core #(.DIV_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .div         (div),
        .mtime_we_lo (mtime_we_lo),
        .mtime_we_hi (mtime_we_hi),
        .mtime_wdata (mtime_wdata),
        .mtimecmp    (mtimecmp),
        .msip_in     (msip_in),
        .mtime       (mtime),
        .tick        (tick),
        .mtip        (mtip),
        .msip_irq    (msip_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] mtime;
        logic        tick;
        logic        mtip;
        logic        msip;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state: mtime value, cycles elapsed since the last
    // tick or load, and the full 64-bit compare result from one edge ago.
    logic [63:0] m_mtime = 64'd0;
    int          m_elapsed = 0;
    logic        m_ge_d1 = 1'b0;

    task automatic check64(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, want);
        end
    endtask

    task automatic model_step();
        exp_t e;
        if (rst) begin
            m_mtime   = 64'd0;
            m_elapsed = 0;
            m_ge_d1   = 1'b0;
            e.tick    = 1'b0;
            e.mtip    = 1'b0;
            e.msip    = 1'b0;
        end else begin
            e.mtip  = m_ge_d1;
            m_ge_d1 = (m_mtime >= mtimecmp);
            e.msip  = msip_in[0];
            e.tick  = 1'b0;
            if (mtime_we_lo || mtime_we_hi) begin
                if (mtime_we_lo) m_mtime[31:0]  = mtime_wdata;
                if (mtime_we_hi) m_mtime[63:32] = mtime_wdata;
                m_elapsed = 0;
            end else if (en) begin
                if (m_elapsed >= int'(div)) begin
                    m_mtime   = m_mtime + 64'd1;
                    m_elapsed = 0;
                    e.tick    = 1'b1;
                end else begin
                    m_elapsed = m_elapsed + 1;
                end
            end
        end
        e.mtime = m_mtime;
        e.cyc   = cyc;
        sb_q.push_back(e);
    endtask

    task automatic drive_cycle();
        model_step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle_inputs();
        mtime_we_lo = 1'b0;
        mtime_we_hi = 1'b0;
        mtime_wdata = 32'd0;
    endtask

    // Monitor: compare DUT outputs just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check64("mtime", mtime, e.mtime);
                check64("tick", {63'd0, tick}, {63'd0, e.tick});
                check64("mtip", {63'd0, mtip}, {63'd0, e.mtip});
                check64("msip_irq", {63'd0, msip_irq}, {63'd0, e.msip});
            end
        end
    end

    initial begin
        int tick_cnt;
        int waited;
        int sel;

        // T1: reset with mtimecmp = 0
        rst = 1'b1; en = 1'b0; div = 16'd0; mtimecmp = 64'd0; msip_in = 32'd0;
        idle_inputs();
        repeat (3) drive_cycle();
        check64("t1_rst_mtime", mtime, 64'd0);
        check64("t1_rst_mtip", {63'd0, mtip}, 64'd0);
        rst = 1'b0;
        drive_cycle();
        check64("t1_mtip_edge1", {63'd0, mtip}, 64'd0);
        drive_cycle();
        check64("t1_mtip_edge2", {63'd0, mtip}, 64'd1);

        // T2: div = 3, tick every 4th cycle, then freeze
        div = 16'd3; en = 1'b1; mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF;
        tick_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            drive_cycle();
            if (tick) tick_cnt++;
        end
        check64("t2_tick_count", 64'(tick_cnt), 64'd4);
        check64("t2_mtime", mtime, 64'd4);
        en = 1'b0;
        repeat (10) drive_cycle();
        check64("t2_frozen", mtime, 64'd4);
        en = 1'b1;
        repeat (4) drive_cycle();
        check64("t2_resume", mtime, 64'd5);

        // T3: carry from bit 31 into bit 32
        div = 16'd0; mtimecmp = 64'h1_0000_0000;
        mtime_we_hi = 1'b1; mtime_wdata = 32'd0;
        drive_cycle();
        mtime_we_hi = 1'b0; mtime_we_lo = 1'b1; mtime_wdata = 32'hFFFF_FFFE;
        drive_cycle();
        idle_inputs();
        drive_cycle();
        drive_cycle();
        check64("t3_carry", mtime, 64'h1_0000_0000);
        drive_cycle();
        check64("t3_mtip_lat1", {63'd0, mtip}, 64'd0);
        drive_cycle();
        check64("t3_mtip_lat2", {63'd0, mtip}, 64'd1);

        // T4: wrap from all-ones with mtimecmp = 5
        mtimecmp = 64'd5;
        mtime_we_lo = 1'b1; mtime_we_hi = 1'b1; mtime_wdata = 32'hFFFF_FFFF;
        drive_cycle();
        idle_inputs();
        drive_cycle();
        check64("t4_wrap", mtime, 64'd0);
        drive_cycle();
        check64("t4_mtip_hold", {63'd0, mtip}, 64'd1);
        drive_cycle();
        check64("t4_mtip_clear", {63'd0, mtip}, 64'd0);
        repeat (7) drive_cycle();
        check64("t4_mtip_again", {63'd0, mtip}, 64'd1);

        // T5: load in a tick cycle, then dual-half load
        div = 16'd2; mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF;
        waited = 0;
        while (m_elapsed < int'(div) && waited < 8) begin
            drive_cycle();
            waited++;
        end
        check64("t5_reach_tick", 64'(m_elapsed), 64'd2);
        mtime_we_lo = 1'b1; mtime_wdata = 32'h10;
        drive_cycle();
        idle_inputs();
        check64("t5_load_lo", {32'd0, mtime[31:0]}, 64'h10);
        check64("t5_load_tick", {63'd0, tick}, 64'd0);
        drive_cycle();
        drive_cycle();
        check64("t5_no_early_tick", {63'd0, tick}, 64'd0);
        drive_cycle();
        check64("t5_tick_after3", {63'd0, tick}, 64'd1);
        mtime_we_lo = 1'b1; mtime_we_hi = 1'b1; mtime_wdata = 32'hA5A5_5A5A;
        drive_cycle();
        idle_inputs();
        check64("t5_load_both", mtime, 64'hA5A5_5A5A_A5A5_5A5A);

        // T6: software interrupt uses only bit 0
        msip_in = 32'h3;
        drive_cycle();
        check64("t6_msip_set", {63'd0, msip_irq}, 64'd1);
        msip_in = 32'h2;
        drive_cycle();
        check64("t6_msip_bit1", {63'd0, msip_irq}, 64'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            en  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 29) == 0) div = 16'($urandom_range(0, 5));
            sel = $urandom_range(0, 9);
            mtime_we_lo = (sel == 0) || (sel == 2);
            mtime_we_hi = (sel == 1) || (sel == 2);
            mtime_wdata = ($urandom_range(0, 1) == 1) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                      : $urandom();
            case ($urandom_range(0, 4))
                0: mtimecmp = m_mtime + 64'($urandom_range(0, 6));
                1: mtimecmp = m_mtime - 64'($urandom_range(0, 6));
                2: mtimecmp = {m_mtime[63:32] + 32'($urandom_range(0, 2)) - 32'd1, $urandom()};
                3: mtimecmp = {$urandom(), $urandom()};
                default: ;
            endcase
            msip_in = $urandom();
            drive_cycle();
        end

        rst = 1'b0;
        idle_inputs();
        @(posedge clk);
        #2;
        check64("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
